// File: rtl/stream_pack.sv
// ============================================================================
// Module      : stream_pack
// Description : Output packer behind the stream controller. Each strobe
//               captures the addressed core's result word into a capture
//               stage. The word then goes into a small first-word-fall-through
//               FIFO, which drives an AXI-Stream style master port.
//               up_ready keeps a two-entry margin, so a beat issued while it
//               is high always finds space.
// Options     : define STREAM_PACK_CNT_EN to add the 16-bit pkt_cnt output.
//               It counts handshakes on last beats and wraps at 0xFFFF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_pack #(
  parameter int NCORE = 16,
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,        // asynchronous, active-low
  input  logic                stream_v,
  input  logic [7:0]          stream_a,
  input  logic [NCORE*DW-1:0] core_data,
  output logic                up_ready,
  output logic                m_valid,
  output logic [DW-1:0]       m_data,
  output logic                m_last,
  input  logic                m_ready,
`ifdef STREAM_PACK_CNT_EN
  output logic [15:0]         pkt_cnt,
`endif
  output logic                err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Capture stage
  logic          s1_v_q;
  logic [DW-1:0] s1_d_q;
  logic          s1_l_q;

  // FIFO state; each entry is {last, data}
  logic [DW:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  // Beat selection and FIFO control
  logic          a_bad;
  logic [DW-1:0] sel_data;
  logic          sel_last;
  logic          push, pop, full, wr_en, drop;

  // Select the addressed core's word; out-of-range indices yield zero.
  always_comb begin
    sel_data = '0;
    a_bad    = (int'(stream_a) >= NCORE);
    sel_last = (int'(stream_a) == NCORE - 1);
    for (int k = 0; k < NCORE; k++) begin
      if (int'(stream_a) == k) sel_data = core_data[k*DW +: DW];
    end
  end

  // Register each strobed beat for one cycle before it enters the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q <= 1'b0;
      s1_d_q <= '0;
      s1_l_q <= 1'b0;
    end else begin
      s1_v_q <= stream_v;
      if (stream_v) begin
        s1_d_q <= sel_data;
        s1_l_q <= sel_last;
      end
    end
  end

  assign push  = s1_v_q;
  assign pop   = m_valid & m_ready;
  assign full  = (count_q == CW'(DEPTH));
  // A simultaneous pop frees the slot that the push needs, even when full.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // Next-state for pointers, occupancy and the sticky error flag.
  always_comb begin
    wptr_d  = wr_en ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop   ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q | drop | (stream_v & a_bad);
  end

  // FIFO storage and control registers; reset clears every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (wr_en) mem_q[wptr_q] <= {s1_l_q, s1_d_q};
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign m_valid          = (count_q != '0);
  assign {m_last, m_data} = mem_q[rptr_q];
  assign err              = err_q;
  // The margin covers the capture stage; depends on registered state only.
  assign up_ready = rst &
                    ((CW'(count_q) + CW'(s1_v_q)) <= CW'(DEPTH - 2));

`ifdef STREAM_PACK_CNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  assign pkt_cnt_d = (pop & m_last) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;

  // Count completed packets; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pkt_cnt_q <= '0;
    else      pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

`default_nettype wire
